pkt_tx_framer: RTL and testbench
================================

Name: pkt_tx_framer

Overview:
- Upstream neighbour of the NI packet processor on the transmit path.
- Accepts a per-packet command (virtual channel and packet size in flits) and a raw data-word stream from the AXI write-data side.
- Frames the words into the head/body/tail request stream the packet processor consumes: valid, req_new, req_last, flit data, vc_id, pkt_sz.
- Registered output with valid/ready backpressure; tracks packet progress with a beat counter.

Parameters:
FlitDataWidth, 32, width of the flit payload (flit type bits excluded)
NumVirtChn, 3, number of virtual channels; VcWidth = $clog2(NumVirtChn) (min 1)
PktWidth, 8, width of the packet-size field; max packet = 2^PktWidth-1 flits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid_i  in  1  packet command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_vc_i  in  VcWidth  target virtual channel
cmd_pkt_sz_i  in  PktWidth  packet length in flits, head included
dat_valid_i  in  1  data word valid
dat_ready_o  out  1  data word accepted when valid&ready
dat_i  in  FlitDataWidth  data word
out_valid_o  out  1  framed flit valid (to packet processor)
out_ready_i  in  1  packet processor / NoC ready
out_req_new_o  out  1  flit is head
out_req_last_o  out  1  flit is tail
out_flit_data_o  out  FlitDataWidth  flit payload
out_vc_id_o  out  VcWidth  virtual channel of flit
out_pkt_sz_o  out  PktWidth  packet size, valid with every flit of the packet
busy_o  out  1  packet in progress (state XFER)
err_zero_sz_o  out  1  one-cycle pulse: zero-size command dropped
pkt_cnt_o  out  16  completed-packet counter, wraps 0xFFFF->0

Behaviour:
- Reset values:
  - state IDLE
  - all out_* = 0; busy_o = 0; err_zero_sz_o = 0; pkt_cnt_o = 0
  - cmd_ready_o = 1; dat_ready_o = 0
- States:
  - IDLE:
    - cmd_ready_o = 1.
    - On cmd handshake with sz != 0: latch vc and sz, clear beat index, go to XFER.
    - On cmd handshake with sz == 0: drop the command, pulse err_zero_sz_o the next cycle, stay in IDLE.
  - XFER:
    - cmd_ready_o = 0.
    - dat_ready_o = !out_valid_o || out_ready_i.
    - Each data handshake loads the output register:
      - out_flit_data_o = dat_i
      - out_vc_id_o and out_pkt_sz_o = latched values
      - out_req_new_o = (idx == 0)
      - out_req_last_o = (idx == sz-1)
      - idx increments.
    - On the handshake where idx == sz-1: go to IDLE.
- Single-flit packet (sz == 1): out_req_new_o = out_req_last_o = 1. The downstream gives head priority.
- Latency: data word to out_valid_o is exactly 1 cycle.
- Throughput: one flit per cycle while out_ready_i stays high.
- Output register:
  - out_valid_o sets on a data handshake.
  - It clears on an out handshake with no new load in the same cycle.
  - Load and drain in the same cycle keep out_valid_o = 1 with the new contents.
  - While out_valid_o = 1 and out_ready_i = 0, all out_* stay stable.
- Between packets:
  - A new command may be accepted in IDLE while the previous tail is still held in the output register.
  - One input-side bubble cycle per packet (the IDLE cycle) is permitted.
- pkt_cnt_o increments on each output handshake with out_req_last_o = 1.
- busy_o = (state == XFER).
- The beat index is PktWidth bits wide; sz ≤ 2^PktWidth-1, so idx never wraps.
- dat_valid_i in IDLE is ignored (dat_ready_o = 0); no data word is consumed.
- rst asserted mid-packet:
  - Next cycle returns to reset values.
  - The partial packet and any held flit are discarded; pkt_cnt_o clears.

Test Plan:
- Command vc=2, sz=4; words 0xA0..0xA3 back-to-back; out_ready=1 -> 4 flits on consecutive cycles starting 1 cycle after first word. Flags new=1 on 0xA0, last=1 on 0xA3, none on 0xA1/0xA2. vc=2, pkt_sz=4 on all four. pkt_cnt_o=1.
- Command sz=1, word 0x55 -> single flit with new=1, last=1. busy_o deasserts the cycle after the handshake.
- Command sz=3; out_ready held 0 for 5 cycles after the first flit -> out_* stable. dat_ready_o=0 while the register is full. All 3 flits delivered in order after release, no loss or duplication.
- Command sz=0 -> cmd accepted, err_zero_sz_o pulses exactly 1 cycle, no out_valid_o, state stays IDLE.
- Packets sz=2 (vc0) then sz=3 (vc1) issued back-to-back -> second command accepted while first tail is held. Output sequence carries correct vc/new/last per flit. pkt_cnt_o=2.
- rst asserted after 2 of 5 flits of a packet -> next cycle out_valid_o=0, busy_o=0, pkt_cnt_o=0, cmd_ready_o=1. A fresh sz=2 packet afterwards frames correctly with new=1 on its first flit.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// Transmit-side framer: turns a per-packet command plus a raw data-word stream
// into the head/body/tail flit request stream of the NI packet processor.
module pkt_tx_framer #(
    parameter int FlitDataWidth = 32,
    parameter int NumVirtChn    = 3,
    parameter int PktWidth      = 8,
    localparam int VcWidth      = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [VcWidth-1:0]       cmd_vc_i,
    input  logic [PktWidth-1:0]      cmd_pkt_sz_i,
    input  logic                     dat_valid_i,
    output logic                     dat_ready_o,
    input  logic [FlitDataWidth-1:0] dat_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_req_new_o,
    output logic                     out_req_last_o,
    output logic [FlitDataWidth-1:0] out_flit_data_o,
    output logic [VcWidth-1:0]       out_vc_id_o,
    output logic [PktWidth-1:0]      out_pkt_sz_o,
    output logic                     busy_o,
    output logic                     err_zero_sz_o,
    output logic [15:0]              pkt_cnt_o
);
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [VcWidth-1:0]       vc_reg;
    logic [PktWidth-1:0]      sz_reg;
    logic [PktWidth-1:0]      idx_reg;
    logic                     out_valid_reg;
    logic                     out_req_new_reg;
    logic                     out_req_last_reg;
    logic [FlitDataWidth-1:0] out_flit_data_reg;
    logic [VcWidth-1:0]       out_vc_id_reg;
    logic [PktWidth-1:0]      out_pkt_sz_reg;
    logic                     err_reg;
    logic [15:0]              pkt_cnt_reg;

    logic cmd_hs, dat_hs, out_hs, last_beat, cmd_zero;

    assign cmd_hs    = cmd_valid_i && cmd_ready_o;
    assign dat_hs    = dat_valid_i && dat_ready_o;
    assign out_hs    = out_valid_reg && out_ready_i;
    assign cmd_zero  = (cmd_pkt_sz_i == '0);
    assign last_beat = (idx_reg == sz_reg - PktWidth'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (cmd_hs && !cmd_zero) state_next = XFER;
            XFER: if (dat_hs && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The output register may be refilled in the same cycle it drains.
    always_comb begin
        cmd_ready_o = (state_reg == IDLE);
        dat_ready_o = (state_reg == XFER) && (!out_valid_reg || out_ready_i);
        busy_o      = (state_reg == XFER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_reg            <= '0;
            sz_reg            <= '0;
            idx_reg           <= '0;
            out_valid_reg     <= 1'b0;
            out_req_new_reg   <= 1'b0;
            out_req_last_reg  <= 1'b0;
            out_flit_data_reg <= '0;
            out_vc_id_reg     <= '0;
            out_pkt_sz_reg    <= '0;
            err_reg           <= 1'b0;
            pkt_cnt_reg       <= '0;
        end else begin
            err_reg <= cmd_hs && cmd_zero;
            if (cmd_hs && !cmd_zero) begin
                vc_reg  <= cmd_vc_i;
                sz_reg  <= cmd_pkt_sz_i;
                idx_reg <= '0;
            end
            if (dat_hs) begin
                out_valid_reg     <= 1'b1;
                out_flit_data_reg <= dat_i;
                out_vc_id_reg     <= vc_reg;
                out_pkt_sz_reg    <= sz_reg;
                out_req_new_reg   <= (idx_reg == '0);
                out_req_last_reg  <= last_beat;
                idx_reg           <= idx_reg + PktWidth'(1);
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
            end
            if (out_hs && out_req_last_reg) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
        end
    end

    assign out_valid_o     = out_valid_reg;
    assign out_req_new_o   = out_req_new_reg;
    assign out_req_last_o  = out_req_last_reg;
    assign out_flit_data_o = out_flit_data_reg;
    assign out_vc_id_o     = out_vc_id_reg;
    assign out_pkt_sz_o    = out_pkt_sz_reg;
    assign err_zero_sz_o   = err_reg;
    assign pkt_cnt_o       = pkt_cnt_reg;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Self-checking bench for pkt_tx_framer: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based packet model.
`timescale 1ns/1ps
module tb_pkt_tx_framer;
    localparam int DW = 32;
    localparam int PW = 8;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [VW-1:0] cmd_vc_i = '0;
    logic [PW-1:0] cmd_pkt_sz_i = '0;
    logic          dat_valid_i = 1'b0;
    logic          dat_ready_o;
    logic [DW-1:0] dat_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic          out_req_new_o;
    logic          out_req_last_o;
    logic [DW-1:0] out_flit_data_o;
    logic [VW-1:0] out_vc_id_o;
    logic [PW-1:0] out_pkt_sz_o;
    logic          busy_o;
    logic          err_zero_sz_o;
    logic [15:0]   pkt_cnt_o;

    always #5 clk = ~clk;

    pkt_tx_framer #(.FlitDataWidth(DW), .NumVirtChn(3), .PktWidth(PW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_vc_i(cmd_vc_i), .cmd_pkt_sz_i(cmd_pkt_sz_i),
        .dat_valid_i(dat_valid_i), .dat_ready_o(dat_ready_o), .dat_i(dat_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_req_new_o(out_req_new_o), .out_req_last_o(out_req_last_o),
        .out_flit_data_o(out_flit_data_o), .out_vc_id_o(out_vc_id_o),
        .out_pkt_sz_o(out_pkt_sz_o), .busy_o(busy_o),
        .err_zero_sz_o(err_zero_sz_o), .pkt_cnt_o(pkt_cnt_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [VW-1:0] vc;
        logic [PW-1:0] sz;
        logic          nw;
        logic          lst;
    } flit_t;

    flit_t       exp_q[$];
    flit_t       obs_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = '0;
    flit_t       m_flit;
    bit          rdy_rand = 1'b0;
    logic        rdy_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s at %0t", name, detail, $time);
    endtask

    task automatic chk_obs(input int idx, input logic [DW-1:0] d, input int vc, input int sz,
                           input bit nw, input bit lst);
        flit_t e;
        e.data = d; e.vc = VW'(vc); e.sz = PW'(sz); e.nw = nw; e.lst = lst;
        if (idx >= obs_q.size()) fail("obs_missing", $sformatf("flit %0d not delivered, required %0h", idx, e));
        else chk($sformatf("obs_flit%0d", idx), obs_q[idx], e);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Model: expected flits come from the packets the driver issued; outputs
    // are predicted from which handshakes the rules allow this cycle.
    always @(negedge clk) begin : monitor
        bit    o_hs, d_hs, c_hs;
        flit_t f;
        if (mon_en) begin
            chk("busy", busy_o, m_busy);
            chk("cmd_ready", cmd_ready_o, !m_busy);
            chk("dat_ready", dat_ready_o, m_busy && (!m_valid || out_ready_i));
            chk("out_valid", out_valid_o, m_valid);
            chk("err_zero_sz", err_zero_sz_o, m_err);
            chk("pkt_cnt", pkt_cnt_o, m_cnt);
            if (m_valid)
                chk("out_flit", {out_flit_data_o, out_vc_id_o, out_pkt_sz_o,
                                 out_req_new_o, out_req_last_o}, m_flit);
        end
        if (rst) begin
            m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_cnt = '0;
            exp_q.delete();
        end else begin
            o_hs  = m_valid && out_ready_i;
            d_hs  = dat_valid_i && m_busy && (!m_valid || out_ready_i);
            c_hs  = cmd_valid_i && !m_busy;
            m_err = c_hs && (cmd_pkt_sz_i == '0);
            if (o_hs) begin
                obs_q.push_back(m_flit);
                if (m_flit.lst) m_cnt++;
                $display("flit vc=%0d sz=%0d new=%0b last=%0b data=%08h",
                         m_flit.vc, m_flit.sz, m_flit.nw, m_flit.lst, m_flit.data);
                m_valid = 1'b0;
            end
            if (d_hs) begin
                if (exp_q.size() == 0) begin
                    fail("data_overrun", "word accepted with no packet open, required none");
                    m_busy = 1'b0;
                end else begin
                    f = exp_q.pop_front();
                    chk("dat_word", dat_i, f.data);
                    m_flit  = f;
                    m_valid = 1'b1;
                    if (f.lst) m_busy = 1'b0;
                end
            end
            if (c_hs && cmd_pkt_sz_i != '0) m_busy = 1'b1;
        end
    end

    // Issues one command and the first n_send of its sz words; returns 1 ns after
    // the final handshake edge.
    task automatic send_pkt(input int vc, input int sz, input int n_send,
                            input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        flit_t         f;
        int            t;
        for (int i = 0; i < sz; i++) begin
            w = rnd ? DW'($urandom) : base + DW'(i);
            words.push_back(w);
            f.data = w; f.vc = VW'(vc); f.sz = PW'(sz); f.nw = (i == 0); f.lst = (i == sz - 1);
            exp_q.push_back(f);
        end
        cmd_valid_i = 1'b1; cmd_vc_i = VW'(vc); cmd_pkt_sz_i = PW'(sz);
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready_o && t < 200);
        if (!cmd_ready_o) begin
            fail("cmd_timeout", "cmd_ready_o stayed 0, required 1");
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            dat_valid_i = 1'b1; dat_i = words[i];
            t = 0;
            do begin @(negedge clk); t++; end while (!dat_ready_o && t < 200);
            if (!dat_ready_o) begin
                fail("dat_timeout", "dat_ready_o stayed 0, required 1");
                dat_valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            dat_valid_i = 1'b0;
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sz;
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_dat_ready", dat_ready_o, 0);
        chk("rst_pkt_cnt", pkt_cnt_o, 0);
        chk("rst_outs", {out_req_new_o, out_req_last_o, out_flit_data_o, out_vc_id_o,
                         out_pkt_sz_o, err_zero_sz_o}, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Four-flit packet, back to back.
        obs_q.delete();
        send_pkt(2, 4, 4, 32'hA0, 0);
        repeat (3) @(negedge clk);
        chk("t1_count", obs_q.size(), 4);
        chk_obs(0, 32'hA0, 2, 4, 1, 0);
        chk_obs(1, 32'hA1, 2, 4, 0, 0);
        chk_obs(2, 32'hA2, 2, 4, 0, 0);
        chk_obs(3, 32'hA3, 2, 4, 0, 1);
        chk("t1_pkt_cnt", pkt_cnt_o, 1);

        // Single-flit packet.
        @(posedge clk); #1;
        obs_q.delete();
        send_pkt(1, 1, 1, 32'h55, 0);
        @(negedge clk);
        chk("t2_busy_clear", busy_o, 0);
        repeat (2) @(negedge clk);
        chk_obs(0, 32'h55, 1, 1, 1, 1);
        chk("t2_pkt_cnt", pkt_cnt_o, 2);

        // Backpressure hold.
        rdy_force = 1'b0;
        @(posedge clk); #1;
        obs_q.delete();
        fork
            send_pkt(0, 3, 3, 32'hC0, 0);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!out_valid_o && t < 50);
                if (!out_valid_o) fail("t3_first_flit", "out_valid_o never rose, required 1");
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_hold_data", out_flit_data_o, 32'hC0);
                    chk("t3_hold_dat_ready", dat_ready_o, 0);
                end
                rdy_force = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("t3_count", obs_q.size(), 3);
        chk_obs(0, 32'hC0, 0, 3, 1, 0);
        chk_obs(1, 32'hC1, 0, 3, 0, 0);
        chk_obs(2, 32'hC2, 0, 3, 0, 1);
        chk("t3_pkt_cnt", pkt_cnt_o, 3);

        // Zero-size command.
        @(posedge clk); #1;
        obs_q.delete();
        send_pkt(1, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("t4_err_pulse", err_zero_sz_o, 1);
        @(negedge clk);
        chk("t4_err_clear", err_zero_sz_o, 0);
        chk("t4_no_flit", obs_q.size() + out_valid_o + busy_o, 0);

        // Back-to-back packets on different channels.
        @(posedge clk); #1;
        obs_q.delete();
        send_pkt(0, 2, 2, 32'hD0, 0);
        send_pkt(1, 3, 3, 32'hE0, 0);
        repeat (3) @(negedge clk);
        chk_obs(0, 32'hD0, 0, 2, 1, 0);
        chk_obs(1, 32'hD1, 0, 2, 0, 1);
        chk_obs(2, 32'hE0, 1, 3, 1, 0);
        chk_obs(3, 32'hE1, 1, 3, 0, 0);
        chk_obs(4, 32'hE2, 1, 3, 0, 1);
        chk("t5_pkt_cnt", pkt_cnt_o, 5);

        // Reset after two of five flits, then a fresh packet.
        @(posedge clk); #1;
        send_pkt(2, 5, 2, 32'hF0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", out_valid_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_pkt_cnt", pkt_cnt_o, 0);
        chk("t6_cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        obs_q.delete();
        send_pkt(1, 2, 2, 32'h11, 0);
        repeat (3) @(negedge clk);
        chk_obs(0, 32'h11, 1, 2, 1, 0);
        chk_obs(1, 32'h12, 1, 2, 0, 1);
        chk("t6_pkt_cnt_after", pkt_cnt_o, 1);

        // Randomized traffic with random backpressure and gaps.
        @(posedge clk); #1;
        rdy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            sz = ($urandom_range(0, 9) == 0) ? 0 :
                 ($urandom_range(0, 7) == 0) ? $urandom_range(7, 20) : $urandom_range(1, 6);
            send_pkt($urandom_range(0, 2), sz, sz, 32'h0, 1);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        repeat (5) @(negedge clk);
        chk("rand_exp_left", exp_q.size(), 0);
        chk("rand_drained", out_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
